f32add_pipe: RTL and testbench

Three-stage pipelined IEEE-754 binary32 adder computing out = a + b, with valid/ready handshakes on both sides. It is the additive, registered counterpart of the combinational f32 subtractor. Its numeric rules match the subtractor bit-for-bit on shared cases, so the two are interchangeable in datapaths that need throughput and backpressure. It sits between operand-issue logic and result-collection logic in the arithmetic library.

---
 rtl/f32_pkg.sv | 28 ++
 rtl/f32_lzc28.sv | 13 +
 rtl/f32add_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_f32add_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/f32_pkg.sv
// rtl/f32_pkg.sv - shared binary32 types, constants and operand classifier
package f32_pkg;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam int          BIAS      = 127;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam int          WIDE_W    = 28;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } f32_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } f32_class_t;

  // Subnormals classify as zero, which is how they get flushed on entry.
  function automatic f32_class_t f32_classify(input f32_t v);
    f32_class_t c;
    c.is_zero = (v.exp == 8'h00);
    c.is_inf  = (v.exp == EXP_MAX) && (v.frac == 23'h0);
    c.is_nan  = (v.exp == EXP_MAX) && (v.frac != 23'h0);
    return c;
  endfunction
endpackage

// File: rtl/f32_lzc28.sv
// rtl/f32_lzc28.sv - combinational 28-bit leading-zero counter; all-zero input returns 28
module f32_lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);
  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end
endmodule

// File: rtl/f32add_pipe.sv
// rtl/f32add_pipe.sv - three-stage pipelined binary32 adder with valid/ready on both sides
module f32add_pipe
  import f32_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [TAG_W-1:0] out_tag
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: classify, swap, align ----------------
  f32_t              a_f, b_f;
  f32_class_t        a_cls, b_cls;
  logic [WIDE_W-1:0] a_mant, b_mant, x_mant, y_mant, y_al;
  logic [7:0]        x_exp, y_exp, exp_diff;
  logic              x_sign, y_sign, sticky;

  assign a_f = in_a;
  assign b_f = in_b;

  always_comb begin
    a_cls  = f32_classify(a_f);
    b_cls  = f32_classify(b_f);
    a_mant = a_cls.is_zero ? '0 : {2'b01, a_f.frac, 3'b000};
    b_mant = b_cls.is_zero ? '0 : {2'b01, b_f.frac, 3'b000};
    if (a_f.exp >= b_f.exp) begin
      x_sign = a_f.sign; x_exp = a_f.exp; x_mant = a_mant;
      y_sign = b_f.sign; y_exp = b_f.exp; y_mant = b_mant;
    end else begin
      x_sign = b_f.sign; x_exp = b_f.exp; x_mant = b_mant;
      y_sign = a_f.sign; y_exp = a_f.exp; y_mant = a_mant;
    end
    exp_diff = x_exp - y_exp;
    // Saturated shift: everything pushed past bit 0 collapses into sticky.
    if (exp_diff >= 8'(WIDE_W)) begin
      sticky = |y_mant;
      y_al   = {{(WIDE_W-1){1'b0}}, sticky};
    end else begin
      sticky = |(y_mant & ~({WIDE_W{1'b1}} << exp_diff));
      y_al   = (y_mant >> exp_diff) | {{(WIDE_W-1){1'b0}}, sticky};
    end
  end

  logic              s1_valid, s1_x_sign, s1_y_sign, s1_a_sign, s1_b_sign;
  logic [7:0]        s1_exp;
  logic [WIDE_W-1:0] s1_x_mant, s1_y_mant;
  f32_class_t        s1_a_cls, s1_b_cls;
  logic [TAG_W-1:0]  s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_x_sign <= 1'b0;
      s1_y_sign <= 1'b0;
      s1_a_sign <= 1'b0;
      s1_b_sign <= 1'b0;
      s1_exp    <= '0;
      s1_x_mant <= '0;
      s1_y_mant <= '0;
      s1_a_cls  <= '0;
      s1_b_cls  <= '0;
      s1_tag    <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_x_sign <= x_sign;
      s1_y_sign <= y_sign;
      s1_a_sign <= a_f.sign;
      s1_b_sign <= b_f.sign;
      s1_exp    <= x_exp;
      s1_x_mant <= x_mant;
      s1_y_mant <= y_al;
      s1_a_cls  <= a_cls;
      s1_b_cls  <= b_cls;
      s1_tag    <= in_tag;
    end
  end

  // ---------------- S2: add/subtract, normalize ----------------
  logic              eff_sub, sum_sign;
  logic [WIDE_W:0]   diff;
  logic [WIDE_W-1:0] mag;
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] norm_exp;

  f32_lzc28 u_lzc (
    .value (mag),
    .count (lz)
  );

  always_comb begin
    eff_sub = s1_x_sign ^ s1_y_sign;
    diff    = {1'b0, s1_x_mant} - {1'b0, s1_y_mant};
    if (!eff_sub) begin
      mag      = s1_x_mant + s1_y_mant;
      sum_sign = s1_x_sign;
    end else if (diff[WIDE_W]) begin
      // Equal exponents with y larger: negate and take y's sign.
      mag      = ~diff[WIDE_W-1:0] + 28'd1;
      sum_sign = s1_y_sign;
    end else begin
      mag      = diff[WIDE_W-1:0];
      sum_sign = s1_x_sign;
    end
    if (mag[WIDE_W-1]) begin
      norm     = {mag[27:2], mag[1] | mag[0]};
      norm_exp = $signed({2'b00, s1_exp}) + 10'sd1;
    end else begin
      norm     = mag[26:0] << (lz - 5'd1);
      norm_exp = $signed({2'b00, s1_exp}) - $signed({5'b00000, lz}) + 10'sd1;
    end
  end

  logic              s2_valid, s2_sign, s2_zero, s2_a_sign, s2_b_sign;
  logic signed [9:0] s2_exp;
  logic [26:0]       s2_mant;
  f32_class_t        s2_a_cls, s2_b_cls;
  logic [TAG_W-1:0]  s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_a_sign <= 1'b0;
      s2_b_sign <= 1'b0;
      s2_exp    <= '0;
      s2_mant   <= '0;
      s2_a_cls  <= '0;
      s2_b_cls  <= '0;
      s2_tag    <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_sign   <= sum_sign;
      s2_zero   <= (mag == '0);
      s2_a_sign <= s1_a_sign;
      s2_b_sign <= s1_b_sign;
      s2_exp    <= norm_exp;
      s2_mant   <= norm;
      s2_a_cls  <= s1_a_cls;
      s2_b_cls  <= s1_b_cls;
      s2_tag    <= s1_tag;
    end
  end

  // ---------------- S3: round, clamp, special override ----------------
  logic              round_up, special;
  logic [24:0]       rounded;
  logic signed [9:0] round_exp;
  logic [22:0]       round_frac;
  logic [31:0]       packed_sum, special_val, result;

  always_comb begin
    round_up   = s2_mant[2] & (s2_mant[1] | s2_mant[0] | s2_mant[3]);
    rounded    = {1'b0, s2_mant[26:3]} + {24'h0, round_up};
    round_exp  = s2_exp + (rounded[24] ? 10'sd1 : 10'sd0);
    round_frac = rounded[24] ? rounded[23:1] : rounded[22:0];

    if (s2_zero)                    packed_sum = 32'h0;
    else if (round_exp <= 10'sd0)   packed_sum = {s2_sign, 31'h0};
    else if (round_exp >= 10'sd255) packed_sum = {s2_sign, EXP_MAX, 23'h0};
    else                            packed_sum = {s2_sign, round_exp[7:0], round_frac};

    special     = 1'b1;
    special_val = CANON_NAN;
    if (s2_a_cls.is_nan || s2_b_cls.is_nan)
      special_val = CANON_NAN;
    else if (s2_a_cls.is_inf && s2_b_cls.is_inf && (s2_a_sign != s2_b_sign))
      special_val = CANON_NAN;
    else if (s2_a_cls.is_inf)
      special_val = {s2_a_sign, EXP_MAX, 23'h0};
    else if (s2_b_cls.is_inf)
      special_val = {s2_b_sign, EXP_MAX, 23'h0};
    else if (s2_a_cls.is_zero && s2_b_cls.is_zero)
      special_val = {s2_a_sign & s2_b_sign, 31'h0};
    else
      special = 1'b0;

    result = special ? special_val : packed_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_sum   <= result;
      out_tag   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_f32add_pipe.sv
// tb/tb_f32add_pipe.sv - self-checking bench for f32add_pipe against a real-arithmetic reference
module tb_f32add_pipe;
  localparam int TAG_W = 4;
  localparam int N_VEC = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  f32add_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_tag   (out_tag)
  );

  logic [31:0] vec_a [N_VEC] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F800000,
                                 32'h7F7FFFFF, 32'h00000001, 32'h3F800000, 32'h3F800001,
                                 32'h7F800001, 32'hFF800000, 32'h00800000, 32'h80800001};
  logic [31:0] vec_b [N_VEC] = '{32'h40000000, 32'hBF800000, 32'h80000000, 32'hFF800000,
                                 32'h7F7FFFFF, 32'h00000000, 32'h33800000, 32'h33800000,
                                 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00800000};
  logic [31:0] vec_s [N_VEC] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h7FC00000,
                                 32'h7F800000, 32'h00000000, 32'h3F800000, 32'h3F800002,
                                 32'h7FC00000, 32'hFF800000, 32'h00800000, 32'h80000000};

  // Flushed binary32 -> binary64 bit pattern (exact).
  function automatic logic [63:0] to_dbl(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h00) return {f[31], 63'h0};
    e = {3'b000, f[30:23]} + 11'd896;
    return {f[31], e, f[22:0], 29'h0};
  endfunction

  // binary64 -> binary32 with round-to-nearest-even, flush on underflow, inf on overflow.
  function automatic logic [31:0] from_dbl(input logic [63:0] d);
    logic [52:0] sig;
    logic [24:0] m;
    logic [28:0] rem;
    logic        up;
    int          e;
    if (d[62:52] == 11'h0) return {d[63], 31'h0};
    sig = {1'b1, d[51:0]};
    m   = {1'b0, sig[52:29]};
    rem = sig[28:0];
    up  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m[0]);
    m   = m + {24'h0, up};
    e   = int'(d[62:52]) - 1023 + 127;
    if (m[24]) begin
      e = e + 1;
      m = m >> 1;
    end
    if (e <= 0)   return {d[63], 31'h0};
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    real  rs;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC00000;
    if (a_inf && b_inf && (a[31] != b[31])) return 32'h7FC00000;
    if (a_inf) return a;
    if (b_inf) return b;
    // A double sum of two floats, rounded again to float, equals the direct RNE result.
    rs = $bitstoreal(to_dbl(a)) + $bitstoreal(to_dbl(b));
    return from_dbl($realtobits(rs));
  endfunction

  function automatic logic [31:0] rand_f32();
    int          k;
    logic [31:0] r;
    k = $urandom_range(0, 15);
    r = $urandom;
    case (k)
      0:       r[30:23] = 8'h00;
      1:       r[30:0]  = {8'hFF, 23'h0};
      2:       r[30:23] = 8'hFF;
      3:       r[30:23] = 8'(240 + $urandom_range(0, 14));
      4:       r[30:23] = 8'(1 + $urandom_range(0, 10));
      default: r[30:23] = 8'(110 + $urandom_range(0, 30));
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_sum !== 32'h0)  begin bad++; $display("FAIL reset_out_sum got=%h want=00000000", out_sum); end
    total++; if (out_tag !== '0)     begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < N_VEC; i++) begin
      int               lat;
      logic             seen;
      logic [TAG_W-1:0] tag;
      tag = TAG_W'(i + 5);
      @(negedge clk);
      in_valid = 1'b1; in_a = vec_a[i]; in_b = vec_b[i]; in_tag = tag; out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_in_ready got=%b want=1", i, in_ready); end
      lat = 0; seen = 1'b0;
      while (!seen && lat < 10) begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
        #1;
        if (out_valid === 1'b1) seen = 1'b1;
      end
      total++; if (!seen || lat != 3) begin bad++; $display("FAIL vec%0d_latency got=%0d want=3", i, lat); end
      total++; if (out_sum !== vec_s[i]) begin bad++; $display("FAIL vec%0d_sum a=%h b=%h got=%h want=%h", i, vec_a[i], vec_b[i], out_sum, vec_s[i]); end
      total++; if (out_tag !== tag) begin bad++; $display("FAIL vec%0d_tag got=%h want=%h", i, out_tag, tag); end
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1; mode 2: random both sides.
  task automatic test_stream(input int n_ops, input int mode);
    logic [31:0]      q_sum[$];
    logic [TAG_W-1:0] q_tag[$];
    logic [31:0]      a, b, want_s;
    logic [TAG_W-1:0] want_t;
    int               sent, got, cyc;
    logic             leak;
    sent = 0; got = 0; cyc = 0;
    while (got < n_ops && cyc < 20 * n_ops + 100) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      cyc++;
      a = rand_f32();
      case ($urandom_range(0, 3))
        0:       b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 255))};
        1:       b = {~a[31], a[30:23] - 8'd1, 23'($urandom)};
        default: b = rand_f32();
      endcase
      in_valid = (sent < n_ops) && ((mode != 2) || ($urandom_range(0, 4) != 0));
      in_a = a; in_b = b; in_tag = TAG_W'(sent);
      #1;
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL stream%0d_in_ready cyc=%0d got=%b out_valid=%b out_ready=%b", mode, cyc, in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        total++;
        if (q_sum.size() == 0) begin
          bad++; $display("FAIL stream%0d_extra got=%h tag=%h want=none", mode, out_sum, out_tag);
        end else begin
          want_s = q_sum.pop_front();
          want_t = q_tag.pop_front();
          if (out_sum !== want_s || out_tag !== want_t) begin
            bad++; $display("FAIL stream%0d_result #%0d got=%h/%h want=%h/%h", mode, got, out_sum, out_tag, want_s, want_t);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_sum.push_back(model_add(a, b));
        q_tag.push_back(TAG_W'(sent));
        sent++;
      end
    end
    total++; if (got != n_ops) begin bad++; $display("FAIL stream%0d_count got=%0d want=%0d", mode, got, n_ops); end
    in_valid = 1'b0; out_ready = 1'b1;
    leak = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    total++; if (leak) begin bad++; $display("FAIL stream%0d_drain got=extra_output want=idle", mode); end
  endtask

  task automatic test_reset_flight();
    logic leak;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      in_a = 32'h3F800000; in_b = 32'(32'h40000000 + i); in_tag = TAG_W'(10 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL flight_full got=valid%b/ready%b want=valid1/ready0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL flight_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    leak = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    total++; if (leak) begin bad++; $display("FAIL flight_discard got=output_seen want=none"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(10, 1);
    test_stream(300, 0);
    test_stream(600, 2);
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
